axis_ad5791_spi_multi: RTL

Parametrised next-generation AXIS-to-AD5791 serializer. Drives NUM_DAC AD5791 DACs in parallel over a shared SCLK/SYNC and one SDO line per DAC. SCLK is generated as a divided clock-enable inside the single a_clk domain. Compared with the 4-channel fixed design, this block adds:
- configurable channel count, SPI divider and SYNC-high hold time
- AD5791 command-prefixed data words
- an LDAC pulse
- busy and frame-count status
It sits between the RPSPMC AXIS output pipeline and the PMOD DAC header.

---
 rtl/axis_ad5791_spi_multi.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/axis_ad5791_spi_multi.sv
// AXIS to AD5791 multi-DAC SPI serializer: shared SCLK/SYNC, one SDO per DAC,
// command-prefixed words, optional LDAC pulse, busy and frame counter.
module axis_ad5791_spi_multi #(
  parameter int NUM_DAC = 4,
  parameter int DAC_DATA_WIDTH = 20,
  parameter int DAC_WORD_WIDTH = 24,
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter logic [DAC_WORD_WIDTH-DAC_DATA_WIDTH-1:0] DATA_CMD = 4'b0001,
  parameter int SCLK_DIV = 4,
  parameter int SYNC_HIGH_CYCLES = 2,
  parameter int LDAC_CYCLES = 4
) (
  input  logic a_clk,
  input  logic a_rst,
  input  logic [NUM_DAC*SAXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_DAC-1:0] s_axis_tvalid,
  input  logic cfg_mode,
  input  logic [2:0] cfg_axis,
  input  logic [DAC_WORD_WIDTH-1:0] cfg_tdata,
  input  logic cfg_tvalid,
  input  logic cfg_send,
  output logic spi_sclk,
  output logic spi_sync_n,
  output logic [NUM_DAC-1:0] spi_sdo,
  output logic ldac_n,
  output logic busy,
  output logic [31:0] frame_count
);
  localparam int HALF = SCLK_DIV / 2;
  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(DAC_WORD_WIDTH);
  localparam int HW = $clog2(SYNC_HIGH_CYCLES + 1);
  localparam int LW = $clog2(LDAC_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, LDAC} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] div_cnt, div_nxt;
  logic rise_tick;
  logic [DAC_WORD_WIDTH-1:0] in_reg [NUM_DAC];
  logic [DAC_WORD_WIDTH-1:0] sent_reg [NUM_DAC];
  logic [BW-1:0] bit_cnt;
  logic [HW-1:0] hold_cnt;
  logic [LW-1:0] ldac_cnt;
  logic mode_f, send_d, send_flag;
  logic data_diff, start_req, start;
  logic unused_bits;

  // Only the MSB-aligned code bits are serialized.
  assign unused_bits = ^s_axis_tdata;

  assign div_nxt = (div_cnt == DW'(SCLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
  assign rise_tick = (div_cnt == DW'(HALF - 1));
  assign start_req = cfg_mode ? send_flag : data_diff;
  assign start = (state == IDLE) && (state_nxt == SHIFT);
  assign busy = (state != IDLE);

  always_comb begin
    data_diff = 1'b0;
    for (int k = 0; k < NUM_DAC; k++)
      if (in_reg[k] != sent_reg[k]) data_diff = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (rise_tick && start_req) state_nxt = SHIFT;
      SHIFT:
        if (rise_tick && bit_cnt == '0) state_nxt = HOLD;
      HOLD:
        if (rise_tick && hold_cnt == HW'(SYNC_HIGH_CYCLES - 1))
          state_nxt = (!mode_f && LDAC_CYCLES > 0) ? LDAC : IDLE;
      LDAC:
        if (ldac_cnt == LW'(LDAC_CYCLES - 1)) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      div_cnt <= '0;
      spi_sclk <= 1'b0;
      send_d <= 1'b0;
      send_flag <= 1'b0;
      spi_sync_n <= 1'b1;
      spi_sdo <= '0;
      ldac_n <= (LDAC_CYCLES != 0);
      frame_count <= '0;
      bit_cnt <= '0;
      hold_cnt <= '0;
      ldac_cnt <= '0;
      mode_f <= 1'b0;
      for (int k = 0; k < NUM_DAC; k++) begin
        in_reg[k] <= '0;
        sent_reg[k] <= '0;
      end
    end else begin
      div_cnt <= div_nxt;
      spi_sclk <= (div_nxt >= DW'(HALF));
      send_d <= cfg_send;
      // An edge arriving while a frame starts stays pending.
      if (cfg_mode && cfg_send && !send_d) send_flag <= 1'b1;
      else if (start) send_flag <= 1'b0;
      for (int k = 0; k < NUM_DAC; k++) begin
        if (!cfg_mode && s_axis_tvalid[k])
          in_reg[k] <= {DATA_CMD,
            s_axis_tdata[k*SAXIS_TDATA_WIDTH + SAXIS_TDATA_WIDTH - 1 -: DAC_DATA_WIDTH]};
        if (cfg_mode && cfg_tvalid && cfg_axis == 3'(k))
          in_reg[k] <= cfg_tdata;
      end
      unique case (state)
        IDLE:
          if (start) begin
            spi_sync_n <= 1'b0;
            bit_cnt <= BW'(DAC_WORD_WIDTH - 1);
            mode_f <= cfg_mode;
            for (int k = 0; k < NUM_DAC; k++) begin
              sent_reg[k] <= in_reg[k];
              spi_sdo[k] <= in_reg[k][DAC_WORD_WIDTH-1];
            end
          end
        SHIFT:
          if (rise_tick) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              for (int k = 0; k < NUM_DAC; k++)
                spi_sdo[k] <= sent_reg[k][bit_cnt - 1'b1];
            end else begin
              spi_sync_n <= 1'b1;
              spi_sdo <= '0;
              hold_cnt <= '0;
            end
          end
        HOLD:
          if (rise_tick) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (state_nxt != HOLD) frame_count <= frame_count + 32'd1;
            if (state_nxt == LDAC) begin
              ldac_n <= 1'b0;
              ldac_cnt <= '0;
            end
          end
        LDAC: begin
          ldac_cnt <= ldac_cnt + 1'b1;
          if (state_nxt == IDLE) ldac_n <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
